// File: rtl/dda_step_decoder.sv
// Decodes a Pulse/Dir step stream into an absolute position and per-window
// sign-magnitude velocity samples queued in a 4-entry first-word-fall-through FIFO.
module dda_step_decoder #(
    parameter int SAMPLE_DIV = 1000,
    parameter int POS_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Pulse,
    input  logic                    Dir,
    input  logic                    RD,
    input  logic                    CLR,
    output logic signed [POS_W-1:0] Pos,
    output logic [7:0]              Q,
    output logic                    Flag_empty,
    output logic                    Flag_full,
    output logic                    Flag_ovf,
    output logic                    Flag_T
);

    localparam int WIN_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_DIV - 1);

    function automatic logic signed [8:0] net_add(input logic signed [8:0] n, input logic up);
        logic signed [9:0] t;
        t = 10'(n) + (up ? 10'sd1 : -10'sd1);
        if (t > 10'sd255)
            return 9'sd255;
        if (t < -10'sd255)
            return -9'sd255;
        return t[8:0];
    endfunction

    function automatic logic [7:0] to_sample(input logic signed [8:0] n);
        logic [8:0] mag;
        mag = n[8] ? 9'(-n) : 9'(n);
        return {(n > 9'sd0), (mag > 9'd127) ? 7'd127 : mag[6:0]};
    endfunction

    logic                    pulse_s1, pulse_s2, pulse_d;
    logic                    dir_s1, dir_s2;
    logic [2:0]              sync_fill;
    logic                    rd_d, clr_d;
    logic                    vld_p0, dir_p0, pop_p0, clr_p0;
    logic                    vld_p1;
    logic [7:0]              sample_p1;
    logic signed [8:0]       net, net_cur;
    logic [WIN_W-1:0]        win;
    logic                    close;

    logic [7:0]              mem [0:3];
    logic [1:0]              rd_ptr, wr_ptr, rd_nxt;
    logic [2:0]              count, count_nxt;
    logic                    pop_ok, wr_en, drop;
    logic [7:0]              q_nxt;

    assign close = (win == WIN_LAST);

    always_comb begin
        net_cur = net;
        if (vld_p0)
            net_cur = net_add(net, dir_p0);
    end

    // stage p0: synchronize inputs and register step/pop/clear events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_s1  <= 1'b0;
            pulse_s2  <= 1'b0;
            pulse_d   <= 1'b0;
            dir_s1    <= 1'b0;
            dir_s2    <= 1'b0;
            sync_fill <= 3'b000;
            rd_d      <= 1'b0;
            clr_d     <= 1'b0;
            vld_p0    <= 1'b0;
            pop_p0    <= 1'b0;
            clr_p0    <= 1'b0;
        end else begin
            pulse_s1  <= Pulse;
            pulse_s2  <= pulse_s1;
            pulse_d   <= pulse_s2;
            dir_s1    <= Dir;
            dir_s2    <= dir_s1;
            // edge register only trusted once it holds a sampled Pulse, so a
            // Pulse held high across reset release is not taken as a step
            sync_fill <= {sync_fill[1:0], 1'b1};
            rd_d      <= RD;
            clr_d     <= CLR;
            vld_p0    <= pulse_s2 & ~pulse_d & sync_fill[2];
            pop_p0    <= RD & ~rd_d;
            clr_p0    <= CLR & ~clr_d;
        end
    end

    // stage p1: position, window accumulator and window close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Pos    <= '0;
            net    <= '0;
            win    <= '0;
            vld_p1 <= 1'b0;
        end else if (clr_p0) begin
            Pos    <= '0;
            net    <= '0;
            win    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (vld_p0)
                Pos <= dir_p0 ? Pos + POS_W'(1) : Pos - POS_W'(1);
            if (close) begin
                win    <= '0;
                net    <= '0;
                vld_p1 <= 1'b1;
            end else begin
                win    <= win + WIN_W'(1);
                net    <= net_cur;
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        dir_p0 <= dir_s2;
        if (close)
            sample_p1 <= to_sample(net_cur);
    end

    always_comb begin
        pop_ok    = pop_p0 && (count != 3'd0);
        wr_en     = vld_p1 && ((count != 3'd4) || pop_ok);
        drop      = vld_p1 && (count == 3'd4) && !pop_ok;
        count_nxt = count;
        if (wr_en && !pop_ok)
            count_nxt = count + 3'd1;
        else if (!wr_en && pop_ok)
            count_nxt = count - 3'd1;
        rd_nxt = pop_ok ? rd_ptr + 2'd1 : rd_ptr;
        q_nxt  = 8'd0;
        // the head is the sample being written only when it lands in an empty queue
        if (count_nxt != 3'd0)
            q_nxt = (wr_en && (wr_ptr == rd_nxt)) ? sample_p1 : mem[rd_nxt];
    end

    // stage p2: FIFO update and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            Q          <= 8'd0;
            Flag_empty <= 1'b1;
            Flag_full  <= 1'b0;
            Flag_ovf   <= 1'b0;
            Flag_T     <= 1'b0;
        end else begin
            Flag_T <= Flag_T ^ vld_p1;
            if (clr_p0) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                Q          <= 8'd0;
                Flag_empty <= 1'b1;
                Flag_full  <= 1'b0;
                Flag_ovf   <= 1'b0;
            end else begin
                rd_ptr     <= rd_nxt;
                count      <= count_nxt;
                Q          <= q_nxt;
                Flag_empty <= (count_nxt == 3'd0);
                Flag_full  <= (count_nxt == 3'd4);
                if (wr_en)
                    wr_ptr <= wr_ptr + 2'd1;
                if (drop)
                    Flag_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr_p0)
            mem[wr_ptr] <= sample_p1;
    end

endmodule

// File: tb/tb_dda_step_decoder.sv
// Bench for dda_step_decoder: window samples predicted into a queue as steps
// are driven, then compared against Q as the host drains the FIFO.
module tb_dda_step_decoder;

    localparam int SDIV = 1000;
    localparam int PW   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 Pulse = 1'b0;
    logic                 Dir = 1'b0;
    logic                 RD = 1'b0;
    logic                 CLR = 1'b0;
    logic signed [PW-1:0] Pos;
    logic [7:0]           Q;
    logic                 Flag_empty, Flag_full, Flag_ovf, Flag_T;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         t_last = 0;
    int         cur_net = 0;
    int         exp_pos = 0;
    logic       exp_t = 1'b0;
    logic [7:0] exp_q[$];

    dda_step_decoder #(.SAMPLE_DIV(SDIV), .POS_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .Pulse(Pulse), .Dir(Dir), .RD(RD), .CLR(CLR),
        .Pos(Pos), .Q(Q), .Flag_empty(Flag_empty), .Flag_full(Flag_full),
        .Flag_ovf(Flag_ovf), .Flag_T(Flag_T)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_sample(input int n);
        int m;
        m = (n < 0) ? -n : n;
        if (m > 127) m = 127;
        return {(n > 0), m[6:0]};
    endfunction

    task automatic step_burst(input int n, input logic d, input int per);
        Dir = d;
        repeat (3) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            Pulse = 1'b1;
            repeat (per / 2) @(negedge clk);
            Pulse = 1'b0;
            repeat (per / 2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        exp_pos += d ? n : -n;
        cur_net += d ? n : -n;
    endtask

    // Waits for a window close; predicts that window's sample into the queue.
    task automatic wait_toggle();
        logic prev;
        bit   seen;
        prev = Flag_T;
        seen = 0;
        for (int i = 0; i < 2 * SDIV + 20 && !seen; i++) begin
            @(negedge clk);
            if (Flag_T !== prev) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL window_close_timeout: Flag_T stuck at %b, required a toggle", prev);
        end
        t_last = cyc;
        exp_t = ~exp_t;
        if (exp_q.size() < 4) exp_q.push_back(exp_sample(cur_net));
        cur_net = 0;
    endtask

    task automatic do_pop();
        RD = 1'b1;
        @(negedge clk);
        RD = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (Pos !== 8'h00) begin errors++; $display("FAIL reset_pos: got %02h required 00", Pos); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %02h required 00", Q); end
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", Flag_empty); end
        checks++; if (Flag_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", Flag_full); end
        checks++; if (Flag_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", Flag_ovf); end
        checks++; if (Flag_T !== 1'b0) begin errors++; $display("FAIL reset_T: got %b required 0", Flag_T); end
    endtask

    task automatic test_forward_burst();
        logic [7:0] e;
        step_burst(10, 1'b1, 8);
        checks++; if (Pos !== PW'(exp_pos)) begin errors++; $display("FAIL fwd_pos: got %02h required %02h", Pos, PW'(exp_pos)); end
        wait_toggle();
        checks++; if (Flag_T !== exp_t) begin errors++; $display("FAIL fwd_T: got %b required %b", Flag_T, exp_t); end
        checks++; if (Flag_empty !== 1'b0) begin errors++; $display("FAIL fwd_empty: got %b required 0", Flag_empty); end
        e = exp_q.pop_front();
        checks++; if (Q !== e) begin errors++; $display("FAIL fwd_sample: got %02h required %02h", Q, e); end
        do_pop();
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got %b required 1", Flag_empty); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL fwd_q_zero: got %02h required 00", Q); end
    endtask

    task automatic test_reverse_mixed();
        logic [7:0] e;
        step_burst(5, 1'b1, 8);
        step_burst(8, 1'b0, 8);
        checks++; if (Pos !== PW'(exp_pos)) begin errors++; $display("FAIL mixed_pos: got %02h required %02h", Pos, PW'(exp_pos)); end
        wait_toggle();
        step_burst(4, 1'b1, 8);
        step_burst(4, 1'b0, 8);
        wait_toggle();
        checks++; if (Flag_T !== exp_t) begin errors++; $display("FAIL mixed_T: got %b required %b", Flag_T, exp_t); end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++; if (Q !== e) begin errors++; $display("FAIL mixed_sample%0d: got %02h required %02h", i, Q, e); end
            do_pop();
        end
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL mixed_drained: got %b required 1", Flag_empty); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] e;
        for (int w = 0; w < 5; w++) begin
            step_burst(3, 1'b1, 8);
            wait_toggle();
            if (w == 3) begin
                checks++; if (Flag_full !== 1'b1) begin errors++; $display("FAIL fill_full4: got %b required 1", Flag_full); end
                checks++; if (Flag_ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf4: got %b required 0", Flag_ovf); end
            end
        end
        checks++; if (Flag_full !== 1'b1) begin errors++; $display("FAIL fill_full5: got %b required 1", Flag_full); end
        checks++; if (Flag_ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf5: got %b required 1", Flag_ovf); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++; if (Q !== e) begin errors++; $display("FAIL fill_sample%0d: got %02h required %02h", i, Q, e); end
            do_pop();
        end
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b required 1", Flag_empty); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL fill_q_zero: got %02h required 00", Q); end
        step_burst(1, 1'b1, 8);
        wait_toggle();
        step_burst(2, 1'b1, 8);
        wait_toggle();
        checks++; if (Q !== exp_q[0]) begin errors++; $display("FAIL hold_head: got %02h required %02h", Q, exp_q[0]); end
        RD = 1'b1;
        repeat (10) @(negedge clk);
        RD = 1'b0;
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (Q !== exp_q[0]) begin errors++; $display("FAIL hold_one_pop: got %02h required %02h", Q, exp_q[0]); end
        checks++; if (Flag_empty !== 1'b0) begin errors++; $display("FAIL hold_not_empty: got %b required 0", Flag_empty); end
        e = exp_q.pop_front();
        do_pop();
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL hold_drained: got %b required 1", Flag_empty); end
    endtask

    task automatic test_clear();
        logic [7:0] e;
        int         c0;
        step_burst(2, 1'b1, 8);
        wait_toggle();
        checks++; if (Flag_empty !== 1'b0) begin errors++; $display("FAIL clr_pre_empty: got %b required 0", Flag_empty); end
        step_burst(3, 1'b1, 8);
        c0 = cyc;
        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        @(negedge clk);
        exp_q.delete();
        exp_pos = 0;
        cur_net = 0;
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b required 1", Flag_empty); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL clr_q: got %02h required 00", Q); end
        checks++; if (Pos !== 8'h00) begin errors++; $display("FAIL clr_pos: got %02h required 00", Pos); end
        checks++; if (Flag_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b required 0", Flag_ovf); end
        checks++; if (Flag_T !== exp_t) begin errors++; $display("FAIL clr_T: got %b required %b", Flag_T, exp_t); end
        step_burst(127, 1'b1, 4);
        checks++; if (Pos !== 8'h7F) begin errors++; $display("FAIL wrap_pre: got %02h required 7f", Pos); end
        step_burst(1, 1'b1, 4);
        checks++; if (Pos !== 8'h80) begin errors++; $display("FAIL wrap_post: got %02h required 80", Pos); end
        wait_toggle();
        checks++; if (t_last - c0 != 1003) begin errors++; $display("FAIL clr_window_len: got %0d required 1003", t_last - c0); end
        e = exp_q.pop_front();
        checks++; if (Q !== e) begin errors++; $display("FAIL clr_sat_sample: got %02h required %02h", Q, e); end
        do_pop();
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL clr_drained: got %b required 1", Flag_empty); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] e;
        int         guard;
        for (int k = 1; k <= 4; k++) begin
            step_burst(k, 1'b1, 4);
            wait_toggle();
        end
        checks++; if (Flag_full !== 1'b1) begin errors++; $display("FAIL pp_pre_full: got %b required 1", Flag_full); end
        step_burst(5, 1'b1, 4);
        guard = 0;
        while (cyc < t_last + SDIV - 2 && guard < 2 * SDIV) begin
            @(negedge clk);
            guard++;
        end
        RD = 1'b1;
        @(negedge clk);
        RD = 1'b0;
        e = exp_q.pop_front();
        wait_toggle();
        checks++; if (Flag_full !== 1'b1) begin errors++; $display("FAIL pp_full: got %b required 1", Flag_full); end
        checks++; if (Flag_ovf !== 1'b0) begin errors++; $display("FAIL pp_ovf: got %b required 0", Flag_ovf); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++; if (Q !== e) begin errors++; $display("FAIL pp_sample%0d: got %02h required %02h", i, Q, e); end
            do_pop();
        end
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL pp_drained: got %b required 1", Flag_empty); end
    endtask

    task automatic test_saturation();
        logic [7:0] e;
        step_burst(200, 1'b1, 4);
        wait_toggle();
        e = exp_q.pop_front();
        checks++; if (Q !== e) begin errors++; $display("FAIL sat_sample: got %02h required %02h", Q, e); end
        checks++; if (Pos !== PW'(exp_pos)) begin errors++; $display("FAIL sat_pos: got %02h required %02h", Pos, PW'(exp_pos)); end
        do_pop();
    endtask

    task automatic test_reset_async();
        step_burst(2, 1'b1, 8);
        wait_toggle();
        step_burst(1, 1'b1, 8);
        wait_toggle();
        checks++; if (Flag_empty !== 1'b0) begin errors++; $display("FAIL arst_pre_empty: got %b required 0", Flag_empty); end
        repeat (100) @(negedge clk);
        Pulse = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Pos !== 8'h00) begin errors++; $display("FAIL arst_pos: got %02h required 00", Pos); end
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL arst_q: got %02h required 00", Q); end
        checks++; if (Flag_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b required 1", Flag_empty); end
        checks++; if (Flag_full !== 1'b0) begin errors++; $display("FAIL arst_full: got %b required 0", Flag_full); end
        checks++; if (Flag_ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b required 0", Flag_ovf); end
        checks++; if (Flag_T !== 1'b0) begin errors++; $display("FAIL arst_T: got %b required 0", Flag_T); end
        exp_q.delete();
        exp_pos = 0;
        cur_net = 0;
        exp_t = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        Pulse = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (Pos !== 8'h00) begin errors++; $display("FAIL arst_held_pulse: got %02h required 00", Pos); end
    endtask

    initial begin
        test_reset();
        test_forward_burst();
        test_reverse_mixed();
        test_fill_overflow();
        test_clear();
        test_push_pop_full();
        test_saturation();
        test_reset_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
